// File: rtl/uart_pkg.sv
// Shared types and timing constants for the board UART.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam int unsigned CLKS_PER_BIT_115200 = 280;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO; full/empty are registered from the next count.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed from a small byte FIFO.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign ready_o = !fifo_full;
    assign push    = valid_i && !fifo_full;
    assign pop     = !fifo_empty &&
                     ((state == IDLE) || (state == STOP && cyc_cnt == LAST_CYC));

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .pop     (pop),
        .wr_data (data_i),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_o)
    );

    // tx_o follows the current state one cycle later, so every bit still
    // spans exactly CLKS_PER_BIT cycles while the pin stays a plain flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            busy_o <= 1'b1;
            unique case (state)
                START:   tx_o <= 1'b0;
                DATA:    tx_o <= shift[0];
                default: tx_o <= 1'b1;
            endcase

            unique case (state)
                IDLE: begin
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        shift <= head;
                        state <= START;
                    end else begin
                        busy_o <= push;
                    end
                end
                START: begin
                    if (cyc_cnt == LAST_CYC) begin
                        cyc_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_cnt == LAST_CYC) begin
                        cyc_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cyc_cnt == LAST_CYC) begin
                        cyc_cnt <= '0;
                        if (!fifo_empty) begin
                            shift <= head;
                            state <= START;
                        end else begin
                            state  <= IDLE;
                            busy_o <= push;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: pushed bytes are queued and checked by a serial receiver model.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 56;
    localparam int unsigned DEPTH = 4;
    localparam int          LIMIT = 60 * CPB;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] fifo_count_o;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         rx_frames = 0;
    bit         rx_armed = 1'b0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (ready_o !== 1'b1 && t < LIMIT) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= LIMIT)
            check("ready_timeout", 32'(ready_o), 32'd1);
        data_i  = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        exp_q.push_back(b);
        #1;
        valid_i = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic busy_drop_delay(output int d);
        int t;
        t = 0;
        while (t < LIMIT) begin
            @(posedge clk_i);
            #1;
            t++;
            if (busy_o === 1'b0)
                break;
        end
        d = cyc;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o !== 1'b0 && t < 20 * LIMIT) begin
            @(negedge clk_i);
            t++;
        end
        check("idle_wait", 32'(busy_o), 32'd0);
        repeat (CPB) @(negedge clk_i);
    endtask

    // Receiver model: samples each bit at its midpoint on the falling clock edge.
    always begin
        logic [7:0] b;
        bit         aborted;
        logic       start_bit;
        logic       stop_bit;
        @(negedge clk_i);
        if (rx_armed && rst_i === 1'b0 && tx_o === 1'b0) begin
            aborted = 1'b0;
            b = '0;
            repeat (CPB / 2) begin
                @(negedge clk_i);
                if (rst_i) aborted = 1'b1;
            end
            start_bit = tx_o;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) begin
                    @(negedge clk_i);
                    if (rst_i) aborted = 1'b1;
                end
                b[i] = tx_o;
            end
            repeat (CPB) begin
                @(negedge clk_i);
                if (rst_i) aborted = 1'b1;
            end
            stop_bit = tx_o;
            if (!aborted) begin
                rx_frames++;
                check("rx_start", 32'(start_bit), 32'd0);
                check("rx_stop", 32'(stop_bit), 32'd1);
                if (exp_q.size() == 0)
                    check("rx_unexpected", 32'(b), 32'hFFFF_FFFF);
                else
                    check("rx_data", 32'(b), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int d;
        int first_acc;
        int frames0;
        logic [7:0] burst [4];
        burst[0] = 8'hA3; burst[1] = 8'h00; burst[2] = 8'hFF; burst[3] = 8'h3C;

        // 1: reset
        repeat (5) @(posedge clk_i);
        #1;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_count", 32'(fifo_count_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rx_armed = 1'b1;
        repeat (3) @(negedge clk_i);
        check("post_rst_tx", 32'(tx_o), 32'd1);

        // 2: single byte, latency and frame length
        push_byte(8'h55);
        first_acc = acc_cyc;
        check("count_after_push", 32'(fifo_count_o), 32'd1);
        check("busy_after_push", 32'(busy_o), 32'd1);
        @(posedge clk_i); #1;
        check("lat_n1_tx", 32'(tx_o), 32'd1);
        @(posedge clk_i); #1;
        check("lat_n2_tx", 32'(tx_o), 32'd0);
        busy_drop_delay(d);
        check("single_busy_len", 32'(d - first_acc), 32'(10 * CPB + 1));
        wait_idle();

        // 3: back-to-back burst, contiguous frames
        for (int i = 0; i < 4; i++) begin
            push_byte(burst[i]);
            if (i == 0) first_acc = acc_cyc;
            check("burst_ready", 32'(ready_o), 32'd1);
        end
        check("burst_contig_accept", 32'(acc_cyc - first_acc), 32'd3);
        busy_drop_delay(d);
        check("burst_busy_len", 32'(d - first_acc), 32'(40 * CPB + 1));
        wait_idle();

        // 4: overflow and stall
        for (int i = 0; i < 6; i++) begin
            push_byte(8'(8'h10 + i));
            if (i == 0) first_acc = acc_cyc;
            if (i == 4) begin
                check("ovf_accept5", 32'(acc_cyc - first_acc), 32'd4);
                check("ovf_ready", 32'(ready_o), 32'd0);
                check("ovf_count", 32'(fifo_count_o), 32'(DEPTH));
            end
        end
        check("ovf_stall_accept", 32'(acc_cyc - first_acc), 32'(10 * CPB + 2));
        wait_idle();

        // 5: reset in the middle of bit 3 of 0x96 with another byte queued
        push_byte(8'h96);
        push_byte(8'h11);
        repeat (1 + 4 * CPB + CPB / 2) @(posedge clk_i);
        #1;
        check("pre_rst_bit3", 32'(tx_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check("midrst_tx", 32'(tx_o), 32'd1);
        check("midrst_count", 32'(fifo_count_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (12 * CPB) @(negedge clk_i);
        check("postrst_idle_tx", 32'(tx_o), 32'd1);
        frames0 = rx_frames;
        push_byte(8'h42);
        wait_idle();
        check("postrst_frames", 32'(rx_frames - frames0), 32'd1);

        // 6: loopback of random bytes
        frames0 = rx_frames;
        for (int i = 0; i < 16; i++)
            push_byte(8'($urandom_range(0, 255)));
        wait_idle();
        check("loop_frames", 32'(rx_frames - frames0), 32'd16);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
